// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: one cipher round per clock, round keys expanded on the fly.
// Optional feature macro AES_ENC_LAST_KEY_EN adds o_Last_Key (final round key, loaded with o_Dout).
module aes_enc_iter #(
    parameter int ROUNDS    = 10,
    parameter int ZERO_IDLE = 1
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_Valid,
    output logic         o_Ready,
    input  logic [127:0] i_Key,
    input  logic [127:0] i_Din,
    output logic         o_Valid,
    input  logic         i_Ready,
    output logic [127:0] o_Dout,
    output logic [3:0]   o_Round_Times
`ifdef AES_ENC_LAST_KEY_EN
    ,
    output logic [127:0] o_Last_Key
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    generate
        if (ROUNDS != 10) begin : g_rounds_check
            $error("aes_enc_iter: only ROUNDS=10 (AES-128) is supported");
        end
    endgenerate

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = 11'd2047 - {b, 3'b000};
        return SBOX_TBL[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [1:0]   r_fsm;
    logic [127:0] r_st;
    logic [127:0] r_key;
    logic [7:0]   r_rcon;
    logic [3:0]   r_round;
    logic [127:0] r_dout;
    logic         r_valid;

    logic [31:0]  w_k0, w_k1, w_k2, w_k3;
    logic [127:0] w_rk;
    logic [127:0] w_sr;
    logic [127:0] w_mc;
    logic [127:0] w_rnd_out;
    logic         w_last;

    // Next round key from the current one; RotWord is folded into the byte order.
    assign w_k0 = r_key[127:96] ^ sub_word({r_key[23:0], r_key[31:24]}) ^ {r_rcon, 24'h0};
    assign w_k1 = r_key[95:64] ^ w_k0;
    assign w_k2 = r_key[63:32] ^ w_k1;
    assign w_k3 = r_key[31:0]  ^ w_k2;
    assign w_rk = {w_k0, w_k1, w_k2, w_k3};

    // SubBytes and ShiftRows together: byte (r,c) comes from column (c+r) mod 4.
    always_comb begin
        w_sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127 - 8*(4*c + r) -: 8] = sbox(r_st[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
    end

    always_comb begin
        w_mc = '0;
        for (int c = 0; c < 4; c++) begin
            w_mc[127 - 32*c -: 32] = mix_col(w_sr[127 - 32*c -: 32]);
        end
    end

    assign w_last    = (r_round == LAST_ROUND);
    assign w_rnd_out = (w_last ? w_sr : w_mc) ^ w_rk;

`ifdef AES_ENC_LAST_KEY_EN
    logic [127:0] r_last_key;
`endif

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_fsm      <= S_IDLE;
            r_st       <= '0;
            r_key      <= '0;
            r_rcon     <= '0;
            r_round    <= '0;
            r_dout     <= '0;
            r_valid    <= 1'b0;
`ifdef AES_ENC_LAST_KEY_EN
            r_last_key <= '0;
`endif
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (i_Valid) begin
                        r_st    <= i_Din ^ i_Key;
                        r_key   <= i_Key;
                        r_rcon  <= 8'h01;
                        r_round <= 4'd1;
                        r_fsm   <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_st   <= w_rnd_out;
                    r_key  <= w_rk;
                    r_rcon <= xtime(r_rcon);
                    if (w_last) begin
                        r_dout     <= w_rnd_out;
                        r_valid    <= 1'b1;
                        r_fsm      <= S_DONE;
`ifdef AES_ENC_LAST_KEY_EN
                        r_last_key <= w_rk;
`endif
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                S_DONE: begin
                    if (i_Ready) begin
                        r_valid <= 1'b0;
                        r_round <= '0;
                        r_fsm   <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign o_Ready       = (r_fsm == S_IDLE);
    assign o_Valid       = r_valid;
    assign o_Round_Times = r_round;
    assign o_Dout        = ((ZERO_IDLE != 0) && !r_valid) ? '0 : r_dout;
`ifdef AES_ENC_LAST_KEY_EN
    assign o_Last_Key    = ((ZERO_IDLE != 0) && !r_valid) ? '0 : r_last_key;
`endif

endmodule

// File: tb/tb_aes_enc_iter.sv
// Self-checking bench for aes_enc_iter: FIPS-197 vectors, backpressure, back-to-back,
// async reset and randomized blocks against a table-free AES-128 reference model.
module tb_aes_enc_iter;

    logic         i_Clk   = 1'b0;
    logic         i_Rst   = 1'b0;
    logic         i_Valid = 1'b0;
    logic         i_Ready = 1'b1;
    logic [127:0] i_Key   = '0;
    logic [127:0] i_Din   = '0;

    logic         o_Ready, o_Valid;
    logic [127:0] o_Dout;
    logic [3:0]   o_Round_Times;
    logic         h_Ready, h_Valid;
    logic [127:0] h_Dout;
    logic [3:0]   h_Round_Times;
`ifdef AES_ENC_LAST_KEY_EN
    logic [127:0] o_Last_Key, h_Last_Key;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb_tbl [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_LK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_LK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    always #5 i_Clk = ~i_Clk;

    aes_enc_iter #(.ROUNDS(10), .ZERO_IDLE(1)) u_dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Valid(i_Valid), .o_Ready(o_Ready),
        .i_Key(i_Key), .i_Din(i_Din), .o_Valid(o_Valid), .i_Ready(i_Ready),
        .o_Dout(o_Dout), .o_Round_Times(o_Round_Times)
`ifdef AES_ENC_LAST_KEY_EN
        , .o_Last_Key(o_Last_Key)
`endif
    );

    aes_enc_iter #(.ROUNDS(10), .ZERO_IDLE(0)) u_hold (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Valid(i_Valid), .o_Ready(h_Ready),
        .i_Key(i_Key), .i_Din(i_Din), .o_Valid(h_Valid), .i_Ready(i_Ready),
        .o_Dout(h_Dout), .o_Round_Times(h_Round_Times)
`ifdef AES_ENC_LAST_KEY_EN
        , .o_Last_Key(h_Last_Key)
`endif
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic aes_ref(input logic [127:0] key, input logic [127:0] pt,
                           output logic [127:0] ct, output logic [127:0] lk);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  rc, a0, a1, a2, a3;
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb_tbl[tmp[23:16]], sb_tbl[tmp[15:8]], sb_tbl[tmp[7:0]], sb_tbl[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++)
            s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int k = 1; k <= 10; k++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r + 4*c] = sb_tbl[s[r + 4*((c + r) % 4)]];
            if (k < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++)
                s[i] = t[i] ^ w[4*k + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127 - 8*i -: 8] = s[i];
        lk = {w[40], w[41], w[42], w[43]};
    endtask

    task automatic check_idle(input string tag, input logic [127:0] last_ct, input logic [127:0] last_lk);
        check_eq({tag, "_valid"}, 128'(o_Valid), 128'(0));
        check_eq({tag, "_ready"}, 128'(o_Ready), 128'(1));
        check_eq({tag, "_round"}, 128'(o_Round_Times), 128'(0));
        check_eq({tag, "_dout_zero"}, o_Dout, '0);
        check_eq({tag, "_hold_dout"}, h_Dout, last_ct);
        check_eq({tag, "_hold_valid"}, 128'(h_Valid), 128'(0));
`ifdef AES_ENC_LAST_KEY_EN
        check_eq({tag, "_lastkey_zero"}, o_Last_Key, '0);
        check_eq({tag, "_hold_lastkey"}, h_Last_Key, last_lk);
`else
        check_eq({tag, "_hold_ready"}, 128'(h_Ready), {127'b0, last_lk[0] | 1'b1});
`endif
    endtask

    task automatic encrypt(input string tag, input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] exp_ct, input logic [127:0] exp_lk, input int hold);
        int cyc;
        logic [127:0] seen;
        cyc = 0;
        while (!o_Ready && cyc < 40) begin
            step();
            cyc++;
        end
        check_eq({tag, "_ready_idle"}, 128'(o_Ready), 128'(1));
        i_Key = key; i_Din = pt; i_Valid = 1'b1;
        step();
        check_eq({tag, "_round_accept"}, 128'(o_Round_Times), 128'(1));
        check_eq({tag, "_busy_dout"}, o_Dout, '0);
        cyc = 0;
        while (!o_Valid && cyc < 40) begin
            i_Valid = 1'($urandom_range(0, 1));
            i_Key = rand128(); i_Din = rand128();
            step();
            cyc++;
        end
        check_eq({tag, "_latency"}, 128'(cyc), 128'(10));
        check_eq({tag, "_round_done"}, 128'(o_Round_Times), 128'(10));
        check_eq({tag, "_ct"}, o_Dout, exp_ct);
        check_eq({tag, "_hold_ct"}, h_Dout, exp_ct);
`ifdef AES_ENC_LAST_KEY_EN
        check_eq({tag, "_lastkey"}, o_Last_Key, exp_lk);
`endif
        if (hold > 0) begin
            i_Ready = 1'b0;
            seen = o_Dout;
            for (int k = 0; k < hold; k++) begin
                i_Valid = 1'($urandom_range(0, 1));
                i_Din = rand128();
                step();
                check_eq({tag, "_bp_dout"}, o_Dout, seen);
                check_eq({tag, "_bp_valid"}, 128'(o_Valid), 128'(1));
                check_eq({tag, "_bp_ready"}, 128'(o_Ready), 128'(0));
            end
        end
        i_Valid = 1'b0;
        i_Ready = 1'b1;
        step();
        check_idle({tag, "_idle"}, exp_ct, exp_lk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] ct, lk, key, pt;
        int cyc;

        build_sbox();

        #1 i_Rst = 1'b1;
        #1;
        check_eq("rst_valid", 128'(o_Valid), 128'(0));
        check_eq("rst_dout", o_Dout, '0);
        check_eq("rst_hold_dout", h_Dout, '0);
        check_eq("rst_round", 128'(o_Round_Times), 128'(0));
        check_eq("rst_ready", 128'(o_Ready), 128'(1));
        @(negedge i_Clk);
        i_Rst = 1'b0;
        step();

        encrypt("c1", C1_KEY, C1_PT, C1_CT, C1_LK, 0);
        encrypt("appb", B_KEY, B_PT, B_CT, B_LK, 20);

        // Back-to-back with i_Valid held high.
        i_Key = C1_KEY; i_Din = C1_PT; i_Valid = 1'b1; i_Ready = 1'b1;
        step();
        check_eq("b2b_first_round", 128'(o_Round_Times), 128'(1));
        i_Key = B_KEY; i_Din = B_PT;
        cyc = 0;
        while (!o_Valid && cyc < 40) begin
            step();
            cyc++;
        end
        check_eq("b2b_lat1", 128'(cyc), 128'(10));
        check_eq("b2b_ct1", o_Dout, C1_CT);
        step();
        check_eq("b2b_gap_ready", 128'(o_Ready), 128'(1));
        check_eq("b2b_gap_valid", 128'(o_Valid), 128'(0));
        step();
        check_eq("b2b_second_round", 128'(o_Round_Times), 128'(1));
        check_eq("b2b_second_busy", 128'(o_Ready), 128'(0));
        i_Valid = 1'b0;
        cyc = 0;
        while (!o_Valid && cyc < 40) begin
            step();
            cyc++;
        end
        check_eq("b2b_lat2", 128'(cyc), 128'(10));
        check_eq("b2b_ct2", o_Dout, B_CT);
        step();
        check_idle("b2b_idle", B_CT, B_LK);

        // Asynchronous reset in round 5.
        i_Key = C1_KEY; i_Din = C1_PT; i_Valid = 1'b1;
        step();
        i_Valid = 1'b0;
        repeat (4) step();
        check_eq("arst_pre_round", 128'(o_Round_Times), 128'(5));
        #2 i_Rst = 1'b1;
        #1;
        check_eq("arst_valid", 128'(o_Valid), 128'(0));
        check_eq("arst_dout", o_Dout, '0);
        check_eq("arst_hold_dout", h_Dout, '0);
        check_eq("arst_round", 128'(o_Round_Times), 128'(0));
        check_eq("arst_ready", 128'(o_Ready), 128'(1));
        #2 i_Rst = 1'b0;
        step();
        encrypt("c1_again", C1_KEY, C1_PT, C1_CT, C1_LK, 2);

        for (int n = 0; n < 8; n++) begin
            key = rand128();
            pt  = rand128();
            aes_ref(key, pt, ct, lk);
            encrypt("rand", key, pt, ct, lk, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_enc_iter.md
Name: aes_enc_iter

Overview:
- Iterative AES-128 encryption core; the forward-direction counterpart of the team's per-round decryption datapath.
- Performs one forward cipher round per clock: SubBytes, ShiftRows, MixColumns (omitted in the final round), then AddRoundKey.
- Expands the round keys on the fly from the cipher key, so the integrator supplies only i_Key.
- Block-level valid/ready handshake on input and output; sits between the host data path and the ciphertext sink.

Parameters:
- ROUNDS, 10, number of cipher rounds; only 10 (AES-128) is legal, elaboration error otherwise.
- ZERO_IDLE, 1, 1 = o_Dout forced to 0 whenever o_Valid is low; 0 = o_Dout holds its last value.

Ports:
- i_Clk  input  1  clock, rising edge.
- i_Rst  input  1  reset, asynchronous, active-high.
- i_Valid  input  1  plaintext block and key are present.
- o_Ready  output  1  core can accept a block this cycle.
- i_Key  input  128  cipher key; sampled only on accept.
- i_Din  input  128  plaintext; sampled only on accept.
- o_Valid  output  1  ciphertext is present on o_Dout.
- i_Ready  input  1  sink accepts o_Dout this cycle.
- o_Dout  output  128  ciphertext.
- o_Round_Times  output  4  current round index (0 when idle), for debug.

Behaviour:
- Byte order follows FIPS-197: bits [127:120] are byte s0,0; column-major.
- States are IDLE, ROUND and DONE.
- o_Ready = (state==IDLE). No other state accepts input; i_Valid outside IDLE is ignored.
- Reset (async, any state): state=IDLE, o_Valid=0, o_Dout=0, o_Round_Times=0, and the state, key and round-constant registers are cleared.
- Accept edge (IDLE, i_Valid=1):
  - state reg <= i_Din^i_Key, key reg <= i_Key, rcon <= 8'h01, round <= 1.
  - Next state is ROUND.
- ROUND, each cycle:
  - Compute the next round key: w0' = w0^SubWord(RotWord(w3))^{rcon,24'h0}, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - Apply the round using that key; the key reg takes the new key.
  - rcon <= xtime(rcon), i.e. {rcon[6:0],1'b0}^(rcon[7]?8'h1b:0).
  - round <= round+1.
  - When round==ROUNDS, MixColumns is bypassed, the result is loaded into o_Dout, o_Valid<=1, and next state is DONE.
- DONE: o_Dout and o_Valid hold stable while i_Ready=0. When i_Ready=1: o_Valid<=0, state<=IDLE.
- Latency: accept edge at cycle 0, o_Valid high after the edge of cycle 10 (10 ROUND cycles).
- Minimum spacing between accepts is 12 cycles when i_Ready is held high.
- o_Round_Times shows 1..10 during ROUND, 10 in DONE and 0 in IDLE.
- i_Key and i_Din may change freely after the accept edge; the result is unaffected.
- Reset asserted mid-ROUND or in DONE discards the block; no partial output is ever flagged valid.
- rcon sequence across rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
- The S-box is a combinational 256-entry lookup. There are 20 instances: 16 for the state and 4 for the key schedule.

Optional Feature:
- AES_ENC_LAST_KEY_EN
- When defined, adds output port o_Last_Key (128). It is loaded together with o_Dout and carries the round-10 key, so the decryption core can start its inverse key schedule without re-expanding.
- It holds with o_Dout while DONE and is cleared by reset. ZERO_IDLE applies to it identically.
- When undefined, the port, its register and the extra load are absent.
- Core behaviour and latency are identical either way.

Test Plan:
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, i_Din 00112233445566778899aabbccddeeff -> o_Dout 69c4e0d86a7b0430d8cdb78070b4c55a, o_Valid rising exactly 10 cycles after accept; with macro, o_Last_Key 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, i_Din 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; with macro, o_Last_Key d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure: hold i_Ready=0 for 20 cycles after o_Valid -> o_Dout stable and o_Ready=0 throughout. Toggle i_Din/i_Valid during that time -> no accept. Release i_Ready -> o_Valid low next cycle, o_Ready high.
- Back-to-back: drive the C.1 then App. B vectors with i_Valid held high and i_Ready=1 -> both correct ciphertexts in order, accepts 12 cycles apart.
- Async reset at round 5 (asserted between edges) -> o_Valid=0, o_Dout=0, o_Round_Times=0 immediately. Re-run C.1 -> correct result.
- ZERO_IDLE=1 -> o_Dout==0 whenever o_Valid=0. ZERO_IDLE=0 -> o_Dout retains the last ciphertext in IDLE.
